crypto_mode_seq: RTL and testbench

- Parametrised block-cipher mode sequencer; successor to the single-shot engine wrapper.
- Processes whole packets (N blocks) in ECB, CBC or CTR mode over valid/ready streams.
- Drives an external cipher core (AES/SM4 mux sits outside) through a start/done port set.
- Adds core watchdog, config latching and a CSR statistics bank; sits between the DMA stream and the cipher cores.

---
 rtl/crypto_pkg.sv | 27 ++
 rtl/crypto_sat_cnt.sv | 37 +++
 rtl/crypto_mode_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_crypto_mode_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// Shared types and constants for the block-cipher mode sequencer.
//   mode_e  : chaining mode selected by cfg_mode
//   state_e : packet sequencer states
//   CSR_*   : CSR read addresses
package crypto_pkg;

  typedef enum logic [1:0] {
    ECB  = 2'd0,
    CBC  = 2'd1,
    CTR  = 2'd2,
    RSVD = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CORE = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [7:0] CSR_MODE    = 8'h10;
  localparam logic [7:0] CSR_ACL_ERR = 8'h44;
  localparam logic [7:0] CSR_TIMEOUT = 8'h48;
  localparam logic [7:0] CSR_BLK_OUT = 8'h4C;

endpackage

// File: rtl/crypto_sat_cnt.sv
// 32-bit saturating event counter.
//   clk   : clock
//   rst   : synchronous active-high reset, clears the count
//   inc   : add one this cycle (held at all-ones once reached)
//   cnt_o : current count
module crypto_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/crypto_mode_seq.sv
// Block-cipher mode sequencer: runs whole packets of DATA_W-bit blocks in
// ECB, CBC or CTR mode through an external cipher core.
//   clk, rst                  : clock, synchronous active-high reset
//   cfg_mode, cfg_algo, start, total_len, iv : packet launch request
//   busy, done, err           : packet status (done pulses once per packet)
//   s_din_*                   : input block stream (valid/ready)
//   m_dout_*                  : output block stream (valid/ready)
//   core_sel, core_start, core_din, core_dout, core_done : cipher core port
//   csr_addr, csr_rdata       : combinational CSR read port
module crypto_mode_seq
  import crypto_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int LEN_W   = 32,
  parameter int TIMEOUT = 1024,
  parameter int CTR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_algo,
  input  logic              start,
  input  logic [LEN_W-1:0]  total_len,
  input  logic [DATA_W-1:0] iv,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              s_din_valid,
  output logic              s_din_ready,
  input  logic [DATA_W-1:0] s_din,
  output logic              m_dout_valid,
  input  logic              m_dout_ready,
  output logic [DATA_W-1:0] m_dout,
  output logic              core_sel,
  output logic              core_start,
  output logic [DATA_W-1:0] core_din,
  input  logic [DATA_W-1:0] core_dout,
  input  logic              core_done,
  input  logic [7:0]        csr_addr,
  output logic [31:0]       csr_rdata
);

  localparam int               BYTES   = DATA_W / 8;
  localparam int               WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0] BYTES_L = LEN_W'(BYTES);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic              algo_q, algo_d;
  logic              start_q;
  logic [DATA_W-1:0] chain_q, chain_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] core_din_q, core_din_d;
  logic [DATA_W-1:0] m_dout_q, m_dout_d;
  logic [LEN_W-1:0]  nblk_q, nblk_d;
  logic [LEN_W-1:0]  blk_q, blk_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              s_din_ready_q, s_din_ready_d;
  logic              m_dout_valid_q, m_dout_valid_d;
  logic              core_start_q, core_start_d;
  logic              acl_inc, to_inc, blk_inc;
  logic [31:0]       acl_cnt, to_cnt, blk_tot;
  logic              start_pulse;
  logic              reject;

  assign start_pulse = start & ~start_q;
  assign reject = (total_len == {LEN_W{1'b0}}) ||
                  ((total_len % BYTES_L) != {LEN_W{1'b0}}) ||
                  (cfg_mode == 2'd3);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    algo_d         = algo_q;
    chain_d        = chain_q;
    hold_d         = hold_q;
    core_din_d     = core_din_q;
    m_dout_d       = m_dout_q;
    nblk_d         = nblk_q;
    blk_d          = blk_q;
    wd_d           = wd_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    core_start_d   = 1'b0;
    acl_inc        = 1'b0;
    to_inc         = 1'b0;
    blk_inc        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_pulse && reject) begin
          // Rejected requests report through done/err without leaving IDLE.
          done_d  = 1'b1;
          err_d   = 1'b1;
          acl_inc = 1'b1;
        end else if (start_pulse) begin
          mode_d  = mode_e'(cfg_mode);
          algo_d  = cfg_algo;
          chain_d = iv;
          nblk_d  = total_len / BYTES_L;
          blk_d   = {LEN_W{1'b0}};
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (s_din_valid && s_din_ready_q) begin
          hold_d       = s_din;
          wd_d         = {WD_W{1'b0}};
          core_start_d = 1'b1;
          state_d      = CORE;
          case (mode_q)
            CBC:     core_din_d = s_din ^ chain_q;
            CTR:     core_din_d = chain_q;
            default: core_din_d = s_din;
          endcase
        end else begin
          state_d = LOAD;
        end
      end
      CORE: begin
        if (core_done) begin
          state_d = OUT;
          case (mode_q)
            CBC: begin
              m_dout_d = core_dout;
              chain_d  = core_dout;
            end
            CTR: begin
              m_dout_d = hold_q ^ core_dout;
              // Only the counter field advances; no carry into the nonce.
              chain_d  = {chain_q[DATA_W-1:CTR_W], chain_q[CTR_W-1:0] + CTR_W'(1)};
            end
            default: m_dout_d = core_dout;
          endcase
        end else if (wd_q == WD_W'(TIMEOUT)) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          to_inc  = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      OUT: begin
        if (m_dout_ready) begin
          blk_inc = 1'b1;
          blk_d   = blk_q + LEN_W'(1);
          if (blk_q == (nblk_q - LEN_W'(1))) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = OUT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered decodes of the upcoming state.
    busy_d         = (state_d != IDLE);
    s_din_ready_d  = (state_d == LOAD);
    m_dout_valid_d = (state_d == OUT);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      mode_q         <= ECB;
      algo_q         <= 1'b0;
      start_q        <= 1'b0;
      chain_q        <= {DATA_W{1'b0}};
      hold_q         <= {DATA_W{1'b0}};
      core_din_q     <= {DATA_W{1'b0}};
      m_dout_q       <= {DATA_W{1'b0}};
      nblk_q         <= {LEN_W{1'b0}};
      blk_q          <= {LEN_W{1'b0}};
      wd_q           <= {WD_W{1'b0}};
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      s_din_ready_q  <= 1'b0;
      m_dout_valid_q <= 1'b0;
      core_start_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      algo_q         <= algo_d;
      start_q        <= start;
      chain_q        <= chain_d;
      hold_q         <= hold_d;
      core_din_q     <= core_din_d;
      m_dout_q       <= m_dout_d;
      nblk_q         <= nblk_d;
      blk_q          <= blk_d;
      wd_q           <= wd_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      s_din_ready_q  <= s_din_ready_d;
      m_dout_valid_q <= m_dout_valid_d;
      core_start_q   <= core_start_d;
    end
  end

  crypto_sat_cnt u_acl_cnt (.clk(clk), .rst(rst), .inc(acl_inc), .cnt_o(acl_cnt));
  crypto_sat_cnt u_to_cnt  (.clk(clk), .rst(rst), .inc(to_inc),  .cnt_o(to_cnt));
  crypto_sat_cnt u_blk_cnt (.clk(clk), .rst(rst), .inc(blk_inc), .cnt_o(blk_tot));

  // CSR read decode.
  always_comb begin
    case (csr_addr)
      CSR_MODE:    csr_rdata = {29'd0, algo_q, mode_q};
      CSR_ACL_ERR: csr_rdata = acl_cnt;
      CSR_TIMEOUT: csr_rdata = to_cnt;
      CSR_BLK_OUT: csr_rdata = blk_tot;
      default:     csr_rdata = 32'd0;
    endcase
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign s_din_ready  = s_din_ready_q;
  assign m_dout_valid = m_dout_valid_q;
  assign m_dout       = m_dout_q;
  assign core_sel     = algo_q;
  assign core_start   = core_start_q;
  assign core_din     = core_din_q;

endmodule

// File: tb/tb_crypto_mode_seq.sv
// Self-checking bench for crypto_mode_seq: randomized packets against a
// reference model of the ECB/CBC/CTR rules, plus rejects, timeout,
// backpressure, held start and mid-packet reset.
module tb_crypto_mode_seq;

  localparam int DW  = 128;
  localparam int TO  = 64;
  localparam logic [127:0] K = {16{8'hA5}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    cfg_mode = 2'd0;
  logic          cfg_algo = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   total_len = 32'd0;
  logic [DW-1:0] iv = '0;
  logic          busy, done, err;
  logic          s_din_valid = 1'b0;
  logic          s_din_ready;
  logic [DW-1:0] s_din = '0;
  logic          m_dout_valid;
  logic          m_dout_ready = 1'b0;
  logic [DW-1:0] m_dout;
  logic          core_sel, core_start;
  logic [DW-1:0] core_din;
  logic [DW-1:0] core_dout = '0;
  logic          core_done = 1'b0;
  logic [7:0]    csr_addr = 8'h00;
  logic [31:0]   csr_rdata;

  int errors = 0;
  int checks = 0;
  int acl_m = 0, to_m = 0, blk_m = 0;
  bit core_dead = 1'b0;
  int cd = 0;
  logic [DW-1:0] core_lat = '0;
  logic [DW-1:0] din_a [16];
  logic [DW-1:0] exp_a [16];

  always #5 clk = ~clk;

  crypto_mode_seq #(.DATA_W(DW), .LEN_W(32), .TIMEOUT(TO), .CTR_W(32)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_algo(cfg_algo),
    .start(start), .total_len(total_len), .iv(iv), .busy(busy), .done(done),
    .err(err), .s_din_valid(s_din_valid), .s_din_ready(s_din_ready),
    .s_din(s_din), .m_dout_valid(m_dout_valid), .m_dout_ready(m_dout_ready),
    .m_dout(m_dout), .core_sel(core_sel), .core_start(core_start),
    .core_din(core_din), .core_dout(core_dout), .core_done(core_done),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata)
  );

  // Cipher core model: result = input ^ A5..A5, done 3 cycles after start.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0 && !core_dead) begin
        core_done = 1'b1;
        core_dout = core_lat ^ K;
      end
    end
    if (core_start) begin
      cd = 3;
      core_lat = core_din;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: expected output blocks from the chaining-mode rules.
  task automatic model_fill(input logic [1:0] mode, input logic [127:0] ivv, input int n);
    logic [127:0] chain;
    chain = ivv;
    for (int i = 0; i < n; i++) begin
      case (mode)
        2'd1: begin
          exp_a[i] = (din_a[i] ^ chain) ^ K;
          chain = exp_a[i];
        end
        2'd2: begin
          exp_a[i] = din_a[i] ^ (chain ^ K);
          chain[31:0] = chain[31:0] + 32'd1;
        end
        default: exp_a[i] = din_a[i] ^ K;
      endcase
    end
  endtask

  task automatic chk_csr(input string tag, input logic [7:0] a, input logic [31:0] e);
    csr_addr = a;
    #1;
    chk(tag, {96'd0, csr_rdata}, {96'd0, e});
  endtask

  task automatic launch(input logic [1:0] mode, input logic algo, input logic [127:0] ivv, input int len);
    @(negedge clk);
    cfg_mode = mode; cfg_algo = algo; iv = ivv; total_len = 32'(len); start = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_packet(input logic [1:0] mode, input logic algo, input logic [127:0] ivv,
                            input int n, input bit bp, input bit hold_st);
    int in_idx = 0, out_idx = 0, cyc = 0, hs_cyc = 0, bp_left;
    bit last_valid = 1'b0, seen_done = 1'b0;
    logic [127:0] last_out = '0;
    bp_left = bp ? 10 : 0;
    model_fill(mode, ivv, n);
    launch(mode, algo, ivv, n * 16);
    if (!hold_st) start = 1'b0;
    chk("busy_after_start", {127'd0, busy}, 128'd1);
    while (cyc < 3000) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (m_dout_valid) begin
        chk("sdin_ready_in_out", {127'd0, s_din_ready}, 128'd0);
        if (!last_valid) chk("latency", 128'(cyc - hs_cyc), 128'd5);
        else chk("dout_stable", m_dout, last_out);
      end
      s_din_valid = (in_idx < n) && ($urandom_range(0, 3) != 0);
      s_din = s_din_valid ? din_a[in_idx] : rnd128();
      if (s_din_ready && s_din_valid) begin
        in_idx++;
        hs_cyc = cyc;
      end
      if (m_dout_valid && bp_left > 0) begin
        m_dout_ready = 1'b0;
        bp_left--;
      end else begin
        m_dout_ready = ($urandom_range(0, 3) != 0);
      end
      if (m_dout_valid && m_dout_ready) begin
        chk("dout", m_dout, exp_a[out_idx]);
        out_idx++;
        blk_m++;
      end
      last_valid = m_dout_valid;
      last_out = m_dout;
      @(negedge clk);
      cyc++;
    end
    if (!seen_done) chk("packet_budget", 128'd0, 128'd1);
    chk("err_ok", {127'd0, err}, 128'd0);
    chk("out_count", 128'(out_idx), 128'(n));
    s_din_valid = 1'b0;
    m_dout_ready = 1'b0;
    @(negedge clk);
    chk("busy_drop", {127'd0, busy}, 128'd0);
    chk("done_pulse", {127'd0, done}, 128'd0);
    if (hold_st) begin
      repeat (5) begin
        @(negedge clk);
        chk("held_start_no_rerun", {127'd0, busy}, 128'd0);
      end
      start = 1'b0;
    end
    chk_csr("csr_mode", 8'h10, {29'd0, algo, mode});
    chk_csr("csr_blocks", 8'h4C, 32'(blk_m));
  endtask

  task automatic do_reject(input logic [1:0] mode, input int len);
    launch(mode, 1'b0, rnd128(), len);
    start = 1'b0;
    chk("rej_done", {127'd0, done}, 128'd1);
    chk("rej_err", {127'd0, err}, 128'd1);
    chk("rej_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    chk("rej_done_once", {127'd0, done}, 128'd0);
    chk("rej_busy2", {127'd0, busy}, 128'd0);
    acl_m++;
    chk_csr("csr_acl", 8'h44, 32'(acl_m));
  endtask

  task automatic wait_core_start(output bit ok);
    int b = 0;
    ok = 1'b0;
    s_din = rnd128();
    s_din_valid = 1'b1;
    while (b < 100 && !core_start) begin
      @(negedge clk);
      b++;
    end
    s_din_valid = 1'b0;
    ok = core_start;
    if (!ok) chk("core_start_seen", 128'd0, 128'd1);
  endtask

  initial begin
    bit ok;
    int t;
    repeat (3) @(negedge clk);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_flags", {124'd0, done, err, s_din_ready, m_dout_valid}, 128'd0);
    chk("rst_core", {126'd0, core_start, core_sel}, 128'd0);
    chk("rst_dout", m_dout, 128'd0);
    chk("rst_core_din", core_din, 128'd0);
    rst = 1'b0;
    chk_csr("rst_csr_blocks", 8'h4C, 32'd0);

    // CBC, two blocks, iv = 0, data 1 then 2.
    din_a[0] = 128'd1; din_a[1] = 128'd2;
    run_packet(2'd1, 1'b0, 128'd0, 2, 1'b0, 1'b0);

    // CTR counter wrap without carry into the upper bits.
    din_a[0] = 128'd0; din_a[1] = 128'd0;
    run_packet(2'd2, 1'b1, {96'h0, 32'hFFFF_FFFF}, 2, 1'b0, 1'b0);

    do_reject(2'd0, 20);
    do_reject(2'd3, 32);
    do_reject(2'd1, 0);

    // Watchdog abort.
    core_dead = 1'b1;
    launch(2'd0, 1'b0, 128'd0, 16);
    start = 1'b0;
    wait_core_start(ok);
    if (ok) begin
      t = 0;
      while (t < TO + 50 && !done) begin
        chk("to_no_valid", {127'd0, m_dout_valid}, 128'd0);
        @(negedge clk);
        t++;
      end
      chk("to_delay", 128'(t), 128'(TO + 1));
      chk("to_err", {127'd0, err}, 128'd1);
      @(negedge clk);
      chk("to_busy_drop", {127'd0, busy}, 128'd0);
      to_m++;
      chk_csr("csr_timeout", 8'h48, 32'(to_m));
    end
    core_dead = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) din_a[i] = rnd128();
    run_packet(2'd0, 1'b0, rnd128(), 3, 1'b0, 1'b0);

    // Backpressure and a start held high for the whole packet.
    for (int i = 0; i < 3; i++) din_a[i] = rnd128();
    run_packet(2'd1, 1'b1, rnd128(), 3, 1'b1, 1'b1);

    // Randomized packets.
    for (int p = 0; p < 10; p++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) din_a[i] = rnd128();
      run_packet(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rnd128(), n,
                 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of a core operation.
    launch(2'd1, 1'b1, rnd128(), 32);
    start = 1'b0;
    wait_core_start(ok);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_flags", {122'd0, busy, done, err, s_din_ready, m_dout_valid, core_start}, 128'd0);
    chk("mid_rst_sel", {127'd0, core_sel}, 128'd0);
    chk("mid_rst_dout", m_dout, 128'd0);
    chk("mid_rst_core_din", core_din, 128'd0);
    rst = 1'b0;
    acl_m = 0; to_m = 0; blk_m = 0;
    chk_csr("mid_rst_acl", 8'h44, 32'd0);
    chk_csr("mid_rst_to", 8'h48, 32'd0);
    chk_csr("mid_rst_blk", 8'h4C, 32'd0);
    chk_csr("csr_other", 8'h20, 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("mid_rst_no_done", {126'd0, done, busy}, 128'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
